xif_copro_responder: RTL and testbench

- Coprocessor-side (responder) end of the CORE-V-XIF 1.0 issue/commit/result interfaces, the counterpart of the CPU-side bridge in core-v-mini-mcu.
- Decodes custom-0 R-type instructions and holds one instruction in flight.
- Waits for the commit decision, executes, then returns a register writeback on the result interface.
- Memory and compressed interfaces are out of scope; the top level ties them off.

---
 rtl/xif_copro_pkg.sv | 39 +++
 rtl/xif_copro_mul.sv | 58 +++++
 rtl/xif_copro_responder.sv | 189 ++++++++++++++++++
 tb/tb_xif_copro_responder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xif_copro_pkg.sv
// Shared definitions for the CORE-V-XIF coprocessor responder.
//   OPCODE_CUSTOM0 / FUNCT7_COPRO : fixed instruction fields decoded by the responder
//   copro_op_e                    : funct3 operation encoding
//   copro_state_e                 : responder FSM states
//   MUL_CYCLES                    : EXEC length of the iterative multiplier
//   op_supported()                : funct3 legality, with or without the multiplier
package xif_copro_pkg;

   localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
   localparam logic [6:0] FUNCT7_COPRO   = 7'b0000000;
   localparam int         MUL_CYCLES     = 32;

   typedef enum logic [2:0] {
      OP_CADD     = 3'b000,
      OP_CSUB     = 3'b001,
      OP_CMUL     = 3'b010,
      OP_CMAX     = 3'b011,
      OP_CMIN     = 3'b100,
      OP_CABSDIFF = 3'b101
   } copro_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_COMMIT,
      ST_EXEC,
      ST_RESULT
   } copro_state_e;

   function automatic logic op_supported(input logic [2:0] funct3, input logic mul_en);
      logic ok;
      case (funct3)
         3'b000, 3'b001, 3'b011, 3'b100, 3'b101: ok = 1'b1;
         3'b010:                                 ok = mul_en;
         default:                                ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/xif_copro_mul.sv
// Iterative radix-2 shift-add multiplier, low WIDTH bits of a*b.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i      : one-cycle pulse, loads a_i/b_i and consumes multiplier bit 0
//   a_i, b_i     : operands
//   done_o       : high in the last of MUL_CYCLES cycles after start; product_o valid
//   product_o    : accumulated product
module xif_copro_mul
   import xif_copro_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o
);

   localparam int            CW       = $clog2(MUL_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
   logic [CW-1:0]    cnt_q;
   logic             running_q;

   // The start cycle already folds in bit 0, so the remaining 31 bits take
   // 31 more cycles and the product is ready in the 32nd cycle after start.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
      end else if (start_i) begin
         acc_q     <= b_i[0] ? a_i : '0;
         mcand_q   <= a_i << 1;
         mplier_q  <= b_i >> 1;
         cnt_q     <= CNT_LAST;
         running_q <= 1'b1;
      end else if (running_q) begin
         if (cnt_q != '0) begin
            acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
         end else begin
            running_q <= 1'b0;
         end
      end
   end

   assign done_o    = running_q && (cnt_q == '0);
   assign product_o = acc_q;

endmodule

// File: rtl/xif_copro_responder.sv
// Coprocessor-side CORE-V-XIF responder: decodes custom-0 R-type ops, holds one
// instruction in flight, waits for commit/kill, executes and returns a writeback.
// Build option: define XIF_COPRO_MUL_EN to accept CMUL (funct3 010) and
// instantiate the 32-cycle iterative multiplier; otherwise CMUL is rejected.
//   clk_i, rst_i                      : clock, asynchronous active-high reset
//   issue_*                           : issue request / accept response
//   commit_valid_i/id_i/kill_i        : commit or kill of an in-flight id
//   result_*                          : register writeback with valid/ready
//   busy_o                            : instruction in flight
//
// state          | meaning
// ST_IDLE        | ready for a new issue
// ST_WAIT_COMMIT | accepted, waiting for commit or kill of id_q
// ST_EXEC        | executing (1 cycle, or until the multiplier is done)
// ST_RESULT      | result offered, waiting for result_ready_i
module xif_copro_responder
   import xif_copro_pkg::*;
#(
   parameter int X_ID_WIDTH  = 4,
   parameter int X_NUM_RS    = 2,
   parameter int X_RFR_WIDTH = 32
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            issue_valid_i,
   output logic                            issue_ready_o,
   input  logic [31:0]                     issue_instr_i,
   input  logic [X_ID_WIDTH-1:0]           issue_id_i,
   input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_rs_i,
   input  logic [X_NUM_RS-1:0]             issue_rs_valid_i,
   output logic                            issue_accept_o,
   output logic                            issue_writeback_o,
   input  logic                            commit_valid_i,
   input  logic [X_ID_WIDTH-1:0]           commit_id_i,
   input  logic                            commit_kill_i,
   output logic                            result_valid_o,
   input  logic                            result_ready_i,
   output logic [X_ID_WIDTH-1:0]           result_id_o,
   output logic [X_RFR_WIDTH-1:0]          result_data_o,
   output logic [4:0]                      result_rd_o,
   output logic                            result_we_o,
   output logic                            busy_o
);

`ifdef XIF_COPRO_MUL_EN
   localparam logic MUL_EN = 1'b1;
`else
   localparam logic MUL_EN = 1'b0;
`endif

   copro_state_e           state_q, state_d;
   copro_op_e              op_q;
   logic [X_ID_WIDTH-1:0]  id_q;
   logic [4:0]             rd_q;
   logic [X_RFR_WIDTH-1:0] rs1_q, rs2_q;
   logic                   load_op, load_result;

   logic [X_RFR_WIDTH-1:0] rs1, rs2, alu_result, exec_result, mul_product;
   logic [2:0]             funct3;
   logic                   decode_ok, hs, commit_hit_new, commit_hit_q, mul_done;

   assign rs1    = issue_rs_i[X_RFR_WIDTH-1:0];
   assign rs2    = issue_rs_i[2*X_RFR_WIDTH-1:X_RFR_WIDTH];
   assign funct3 = issue_instr_i[14:12];

   assign decode_ok = (issue_instr_i[6:0] == OPCODE_CUSTOM0) &&
                      (issue_instr_i[31:25] == FUNCT7_COPRO) &&
                      op_supported(funct3, MUL_EN);

   assign issue_accept_o    = issue_valid_i && decode_ok && (issue_rs_valid_i[1:0] == 2'b11);
   assign issue_writeback_o = issue_accept_o;
   assign issue_ready_o     = (state_q == ST_IDLE);
   assign result_valid_o    = (state_q == ST_RESULT);
   assign busy_o            = (state_q != ST_IDLE);

   assign hs             = issue_ready_o && issue_accept_o;
   assign commit_hit_new = commit_valid_i && (commit_id_i == issue_id_i);
   assign commit_hit_q   = commit_valid_i && (commit_id_i == id_q);

   // Register-file source fields are implied by the operands and never used.
   logic unused_instr;
   assign unused_instr = ^issue_instr_i[24:15];

   if (X_NUM_RS > 2) begin : g_extra_rs
      logic unused_rs;
      assign unused_rs = ^{issue_rs_i[X_NUM_RS*X_RFR_WIDTH-1:2*X_RFR_WIDTH],
                           issue_rs_valid_i[X_NUM_RS-1:2]};
   end

`ifdef XIF_COPRO_MUL_EN
   logic                   mul_start;
   logic [X_RFR_WIDTH-1:0] mul_a, mul_b;

   // A commit in the issue cycle starts the multiplier before the operands are
   // latched, so it takes them straight from the issue bus.
   assign mul_start = (state_q == ST_IDLE && hs && commit_hit_new && !commit_kill_i &&
                       funct3 == OP_CMUL) ||
                      (state_q == ST_WAIT_COMMIT && commit_hit_q && !commit_kill_i &&
                       op_q == OP_CMUL);
   assign mul_a = (state_q == ST_IDLE) ? rs1 : rs1_q;
   assign mul_b = (state_q == ST_IDLE) ? rs2 : rs2_q;

   xif_copro_mul #(.WIDTH(X_RFR_WIDTH)) u_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (mul_start),
      .a_i       (mul_a),
      .b_i       (mul_b),
      .done_o    (mul_done),
      .product_o (mul_product)
   );
`else
   assign mul_done    = 1'b0;
   assign mul_product = '0;
`endif

   always_comb begin
      alu_result = '0;
      case (op_q)
         OP_CADD:     alu_result = rs1_q + rs2_q;
         OP_CSUB:     alu_result = rs1_q - rs2_q;
         OP_CMAX:     alu_result = ($signed(rs1_q) > $signed(rs2_q)) ? rs1_q : rs2_q;
         OP_CMIN:     alu_result = ($signed(rs1_q) < $signed(rs2_q)) ? rs1_q : rs2_q;
         OP_CABSDIFF: alu_result = (rs1_q > rs2_q) ? (rs1_q - rs2_q) : (rs2_q - rs1_q);
         default:     alu_result = '0;
      endcase
   end

   assign exec_result = (op_q == OP_CMUL) ? mul_product : alu_result;

   always_comb begin
      state_d     = state_q;
      load_op     = 1'b0;
      load_result = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               load_op = 1'b1;
               if (commit_hit_new) state_d = commit_kill_i ? ST_IDLE : ST_EXEC;
               else                state_d = ST_WAIT_COMMIT;
            end
         end
         ST_WAIT_COMMIT: begin
            if (commit_hit_q) state_d = commit_kill_i ? ST_IDLE : ST_EXEC;
         end
         ST_EXEC: begin
            if (op_q != OP_CMUL || mul_done) begin
               load_result = 1'b1;
               state_d     = ST_RESULT;
            end
         end
         ST_RESULT: begin
            if (result_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         op_q          <= OP_CADD;
         id_q          <= '0;
         rd_q          <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         result_id_o   <= '0;
         result_data_o <= '0;
         result_rd_o   <= '0;
         result_we_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_op) begin
            op_q  <= copro_op_e'(funct3);
            id_q  <= issue_id_i;
            rd_q  <= issue_instr_i[11:7];
            rs1_q <= rs1;
            rs2_q <= rs2;
         end
         if (load_result) begin
            result_id_o   <= id_q;
            result_data_o <= exec_result;
            result_rd_o   <= rd_q;
            result_we_o   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_xif_copro_responder.sv
module tb_xif_copro_responder;

   localparam int IDW = 4;
   localparam int NRS = 2;
   localparam int W   = 32;

`ifdef XIF_COPRO_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic           issue_valid_i = 1'b0;
   logic           issue_ready_o;
   logic [31:0]    issue_instr_i = '0;
   logic [IDW-1:0] issue_id_i = '0;
   logic [NRS*W-1:0] issue_rs_i = '0;
   logic [NRS-1:0] issue_rs_valid_i = '0;
   logic           issue_accept_o, issue_writeback_o;
   logic           commit_valid_i = 1'b0;
   logic [IDW-1:0] commit_id_i = '0;
   logic           commit_kill_i = 1'b0;
   logic           result_valid_o;
   logic           result_ready_i = 1'b0;
   logic [IDW-1:0] result_id_o;
   logic [W-1:0]   result_data_o;
   logic [4:0]     result_rd_o;
   logic           result_we_o, busy_o;

   int checks = 0;
   int passes = 0;

   xif_copro_responder #(.X_ID_WIDTH(IDW), .X_NUM_RS(NRS), .X_RFR_WIDTH(W)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
      .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
      .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_id_o(result_id_o), .result_data_o(result_data_o),
      .result_rd_o(result_rd_o), .result_we_o(result_we_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] opc);
      return {f7, 5'd2, 5'd1, f3, rd, opc};
   endfunction

   function automatic logic ref_accept(input logic [31:0] instr, input logic [1:0] rsv);
      logic [6:0] opc, f7;
      logic [2:0] f3;
      logic       op_ok;
      opc = instr[6:0];
      f7  = instr[31:25];
      f3  = instr[14:12];
      op_ok = (f3 <= 3'd5) && (f3 != 3'd2 || MUL_EN);
      return (opc == 7'h0B) && (f7 == 7'h00) && op_ok && (rsv == 2'b11);
   endfunction

   function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      int          sa, sb;
      logic [63:0] p;
      sa = a;
      sb = b;
      p  = {32'd0, a} * {32'd0, b};
      case (f3)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return p[31:0];
         3'd3:    return (sa > sb) ? a : b;
         3'd4:    return (sa < sb) ? a : b;
         3'd5:    return (a > b) ? a - b : b - a;
         default: return 32'd0;
      endcase
   endfunction

   // ---------------- drivers ----------------
   task automatic drive_issue(input logic [31:0] instr, input logic [IDW-1:0] id,
                              input logic [31:0] a, input logic [31:0] b, input logic [1:0] rsv);
      issue_valid_i    = 1'b1;
      issue_instr_i    = instr;
      issue_id_i       = id;
      issue_rs_i       = {b, a};
      issue_rs_valid_i = rsv;
   endtask

   task automatic drive_commit(input logic [IDW-1:0] id, input logic kill);
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
   endtask

   // Counts negedges after the edge that consumes the commit until result_valid_o.
   task automatic wait_valid(input int bound, output int cyc);
      cyc = 0;
      while (cyc < bound) begin
         @(negedge clk_i);
         issue_valid_i  = 1'b0;
         commit_valid_i = 1'b0;
         commit_kill_i  = 1'b0;
         cyc++;
         if (result_valid_o) break;
      end
   endtask

   task automatic take_result();
      result_ready_i = 1'b1;
      @(negedge clk_i);
      result_ready_i = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", issue_ready_o); else passes++;
      checks++; if (result_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", result_valid_o); else passes++;
      checks++; if (result_data_o !== 32'd0) $display("FAIL rst_data: got %h want 0", result_data_o); else passes++;
      checks++; if (result_id_o !== 4'd0) $display("FAIL rst_id: got %h want 0", result_id_o); else passes++;
      checks++; if (result_rd_o !== 5'd0) $display("FAIL rst_rd: got %h want 0", result_rd_o); else passes++;
      checks++; if (result_we_o !== 1'b0) $display("FAIL rst_we: got %b want 0", result_we_o); else passes++;
      checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else passes++;
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic test_cadd();
      int cyc;
      drive_issue(32'h0020_850B, 4'd3, 32'd7, 32'd5, 2'b11);
      #1;
      checks++; if (issue_accept_o !== 1'b1) $display("FAIL cadd_accept: got %b want 1", issue_accept_o); else passes++;
      checks++; if (issue_writeback_o !== 1'b1) $display("FAIL cadd_wb: got %b want 1", issue_writeback_o); else passes++;
      @(negedge clk_i);
      issue_valid_i = 1'b0;
      checks++; if (issue_ready_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL cadd_wait: got ready=%b busy=%b want 0/1", issue_ready_o, busy_o); else passes++;
      drive_commit(4'd3, 1'b0);
      wait_valid(10, cyc);
      checks++; if (result_valid_o !== 1'b1 || cyc != 2) $display("FAIL cadd_latency: got valid=%b cyc=%0d want 1/2", result_valid_o, cyc); else passes++;
      checks++; if (result_data_o !== 32'd12) $display("FAIL cadd_data: got %h want %h", result_data_o, 32'd12); else passes++;
      checks++; if (result_rd_o !== 5'd10) $display("FAIL cadd_rd: got %0d want 10", result_rd_o); else passes++;
      checks++; if (result_id_o !== 4'd3) $display("FAIL cadd_id: got %0d want 3", result_id_o); else passes++;
      checks++; if (result_we_o !== 1'b1) $display("FAIL cadd_we: got %b want 1", result_we_o); else passes++;
      take_result();
      checks++; if (issue_ready_o !== 1'b1 || result_valid_o !== 1'b0) $display("FAIL cadd_idle: got ready=%b valid=%b want 1/0", issue_ready_o, result_valid_o); else passes++;
   endtask

   task automatic test_kill();
      int cyc, bad;
      drive_issue(mk_instr(7'h00, 3'd1, 5'd7, 7'h0B), 4'd2, 32'd9, 32'd4, 2'b11);
      #1;
      checks++; if (issue_accept_o !== 1'b1) $display("FAIL kill_accept: got %b want 1", issue_accept_o); else passes++;
      @(negedge clk_i);
      issue_valid_i = 1'b0;
      drive_commit(4'd2, 1'b1);
      @(negedge clk_i);
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
      checks++; if (busy_o !== 1'b0 || issue_ready_o !== 1'b1) $display("FAIL kill_idle: got busy=%b ready=%b want 0/1", busy_o, issue_ready_o); else passes++;
      bad = 0;
      repeat (50) begin
         @(negedge clk_i);
         if (result_valid_o !== 1'b0) bad++;
      end
      checks++; if (bad != 0) $display("FAIL kill_no_result: got %0d valid cycles want 0", bad); else passes++;
      drive_issue(mk_instr(7'h00, 3'd0, 5'd1, 7'h0B), 4'd6, 32'd100, 32'd23, 2'b11);
      drive_commit(4'd6, 1'b0);
      #1;
      checks++; if (issue_accept_o !== 1'b1) $display("FAIL kill_next_accept: got %b want 1", issue_accept_o); else passes++;
      wait_valid(10, cyc);
      checks++; if (result_valid_o !== 1'b1 || result_data_o !== 32'd123) $display("FAIL kill_next_data: got valid=%b data=%h want 1/%h", result_valid_o, result_data_o, 32'd123); else passes++;
      take_result();
   endtask

   task automatic test_same_cycle_bp();
      int cyc, bad;
      drive_issue(mk_instr(7'h00, 3'd3, 5'd5, 7'h0B), 4'd1, 32'hFFFF_FFFF, 32'd1, 2'b11);
      drive_commit(4'd1, 1'b0);
      #1;
      checks++; if (issue_accept_o !== 1'b1) $display("FAIL cmax_accept: got %b want 1", issue_accept_o); else passes++;
      wait_valid(10, cyc);
      checks++; if (result_valid_o !== 1'b1 || cyc != 2) $display("FAIL cmax_latency: got valid=%b cyc=%0d want 1/2", result_valid_o, cyc); else passes++;
      checks++; if (result_data_o !== 32'd1) $display("FAIL cmax_data: got %h want 1", result_data_o); else passes++;
      bad = 0;
      repeat (5) begin
         @(negedge clk_i);
         if (result_valid_o !== 1'b1 || result_data_o !== 32'd1 || result_id_o !== 4'd1 ||
             result_rd_o !== 5'd5 || result_we_o !== 1'b1) bad++;
      end
      checks++; if (bad != 0) $display("FAIL cmax_stable: got %0d unstable cycles want 0", bad); else passes++;
      take_result();
      checks++; if (issue_ready_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL cmax_idle: got ready=%b busy=%b want 1/0", issue_ready_o, busy_o); else passes++;
   endtask

   task automatic test_mul();
`ifdef XIF_COPRO_MUL_EN
      int cyc;
      drive_issue(mk_instr(7'h00, 3'd2, 5'd8, 7'h0B), 4'd7, 32'h0001_0003, 32'h0000_0010, 2'b11);
      drive_commit(4'd7, 1'b0);
      #1;
      checks++; if (issue_accept_o !== 1'b1) $display("FAIL cmul_accept: got %b want 1", issue_accept_o); else passes++;
      wait_valid(60, cyc);
      checks++; if (result_valid_o !== 1'b1 || cyc != 33) $display("FAIL cmul_latency: got valid=%b cyc=%0d want 1/33", result_valid_o, cyc); else passes++;
      checks++; if (result_data_o !== 32'h0010_0030) $display("FAIL cmul_data: got %h want %h", result_data_o, 32'h0010_0030); else passes++;
      take_result();
`else
      drive_issue(mk_instr(7'h00, 3'd2, 5'd8, 7'h0B), 4'd7, 32'h0001_0003, 32'h0000_0010, 2'b11);
      #1;
      checks++; if (issue_accept_o !== 1'b0) $display("FAIL cmul_reject: got %b want 0", issue_accept_o); else passes++;
      @(negedge clk_i);
      issue_valid_i = 1'b0;
      checks++; if (issue_ready_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL cmul_idle: got ready=%b busy=%b want 1/0", issue_ready_o, busy_o); else passes++;
`endif
   endtask

   task automatic test_reject();
      logic [31:0] instr [4];
      logic [1:0]  rsv   [4];
      instr[0] = mk_instr(7'h00, 3'd0, 5'd1, 7'h33); rsv[0] = 2'b11;
      instr[1] = mk_instr(7'h00, 3'd7, 5'd1, 7'h0B); rsv[1] = 2'b11;
      instr[2] = mk_instr(7'h00, 3'd0, 5'd1, 7'h0B); rsv[2] = 2'b01;
      instr[3] = mk_instr(7'h01, 3'd0, 5'd1, 7'h0B); rsv[3] = 2'b11;
      for (int i = 0; i < 4; i++) begin
         drive_issue(instr[i], 4'(i), 32'd1, 32'd2, rsv[i]);
         #1;
         checks++; if (issue_accept_o !== 1'b0 || issue_writeback_o !== 1'b0) $display("FAIL reject_%0d: got accept=%b wb=%b want 0/0", i, issue_accept_o, issue_writeback_o); else passes++;
         @(negedge clk_i);
         issue_valid_i = 1'b0;
         checks++; if (issue_ready_o !== 1'b1) $display("FAIL reject_idle_%0d: got ready=%b want 1", i, issue_ready_o); else passes++;
      end
   endtask

   task automatic test_mismatch();
      int cyc;
      drive_issue(mk_instr(7'h00, 3'd0, 5'd3, 7'h0B), 4'd4, 32'd1, 32'd2, 2'b11);
      #1;
      checks++; if (issue_accept_o !== 1'b1) $display("FAIL mism_accept: got %b want 1", issue_accept_o); else passes++;
      @(negedge clk_i);
      issue_valid_i = 1'b0;
      drive_commit(4'd5, 1'b0);
      @(negedge clk_i);
      drive_commit(4'd5, 1'b1);
      @(negedge clk_i);
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++; if (busy_o !== 1'b1 || issue_ready_o !== 1'b0) $display("FAIL mism_pending: got busy=%b ready=%b want 1/0", busy_o, issue_ready_o); else passes++;
      checks++; if (result_valid_o !== 1'b0) $display("FAIL mism_no_result: got %b want 0", result_valid_o); else passes++;
      drive_commit(4'd4, 1'b0);
      wait_valid(10, cyc);
      checks++; if (result_valid_o !== 1'b1 || cyc != 2 || result_data_o !== 32'd3) $display("FAIL mism_result: got valid=%b cyc=%0d data=%h want 1/2/3", result_valid_o, cyc, result_data_o); else passes++;
      take_result();
   endtask

   task automatic test_reset_mid();
      int bad;
`ifdef XIF_COPRO_MUL_EN
      drive_issue(mk_instr(7'h00, 3'd2, 5'd9, 7'h0B), 4'd9, 32'h1234_5678, 32'h0000_0777, 2'b11);
      drive_commit(4'd9, 1'b0);
`else
      drive_issue(mk_instr(7'h00, 3'd0, 5'd9, 7'h0B), 4'd9, 32'h1234_5678, 32'h0000_0777, 2'b11);
`endif
      repeat (10) begin
         @(negedge clk_i);
         issue_valid_i  = 1'b0;
         commit_valid_i = 1'b0;
      end
      #2;
      rst_i = 1'b1;
      #1;
      checks++; if (issue_ready_o !== 1'b1 || result_valid_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL rstmid_state: got ready=%b valid=%b busy=%b want 1/0/0", issue_ready_o, result_valid_o, busy_o); else passes++;
      @(negedge clk_i);
      checks++; if (result_data_o !== 32'd0 || result_we_o !== 1'b0) $display("FAIL rstmid_outputs: got data=%h we=%b want 0/0", result_data_o, result_we_o); else passes++;
      rst_i = 1'b0;
      drive_commit(4'd9, 1'b0);
      bad = 0;
      repeat (40) begin
         @(negedge clk_i);
         commit_valid_i = 1'b0;
         if (result_valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
      end
      checks++; if (bad != 0) $display("FAIL rstmid_stale: got %0d active cycles want 0", bad); else passes++;
   endtask

   task automatic test_random();
      logic [31:0] corner [4];
      logic [31:0] instr, a, b, exp_data;
      logic [2:0]  f3;
      logic [6:0]  opc, f7;
      logic [1:0]  rsv;
      logic [4:0]  rd;
      logic [IDW-1:0] id;
      logic        exp_acc;
      int          mode, cyc, exp_lat, k;
      corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF;
      corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;
      for (int it = 0; it < 40; it++) begin
         f3  = 3'($urandom_range(0, 7));
         opc = ($urandom_range(0, 9) == 0) ? 7'h33 : 7'h0B;
         f7  = ($urandom_range(0, 9) == 0) ? 7'h20 : 7'h00;
         rsv = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         rd  = 5'($urandom_range(0, 31));
         id  = IDW'($urandom_range(0, 15));
         a   = $urandom();
         b   = $urandom();
         if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 3)];
         if ($urandom_range(0, 3) == 0) b = corner[$urandom_range(0, 3)];
         instr    = mk_instr(f7, f3, rd, opc);
         exp_acc  = ref_accept(instr, rsv);
         exp_data = ref_alu(f3, a, b);
         exp_lat  = (f3 == 3'd2) ? 33 : 2;
         mode     = $urandom_range(0, 3);
         drive_issue(instr, id, a, b, rsv);
         if (mode == 0) drive_commit(id, 1'b0);
         if (mode == 3) drive_commit(id, 1'b1);
         #1;
         checks++; if (issue_accept_o !== exp_acc) $display("FAIL rnd_accept_%0d: got %b want %b instr=%h", it, issue_accept_o, exp_acc, instr); else passes++;
         if (!exp_acc || mode == 3) begin
            @(negedge clk_i);
            issue_valid_i  = 1'b0;
            commit_valid_i = 1'b0;
            commit_kill_i  = 1'b0;
            checks++; if (issue_ready_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL rnd_idle_%0d: got ready=%b busy=%b want 1/0", it, issue_ready_o, busy_o); else passes++;
         end else begin
            if (mode != 0) begin
               @(negedge clk_i);
               issue_valid_i = 1'b0;
               k = $urandom_range(0, 3);
               repeat (k) begin
                  drive_commit(id ^ IDW'(1), 1'b0);
                  @(negedge clk_i);
                  commit_valid_i = 1'b0;
               end
               drive_commit(id, mode == 2);
            end
            if (mode == 2) begin
               @(negedge clk_i);
               commit_valid_i = 1'b0;
               commit_kill_i  = 1'b0;
               checks++; if (busy_o !== 1'b0 || result_valid_o !== 1'b0) $display("FAIL rnd_kill_%0d: got busy=%b valid=%b want 0/0", it, busy_o, result_valid_o); else passes++;
            end else begin
               wait_valid(60, cyc);
               checks++; if (result_valid_o !== 1'b1 || cyc != exp_lat) $display("FAIL rnd_latency_%0d: got valid=%b cyc=%0d want 1/%0d", it, result_valid_o, cyc, exp_lat); else passes++;
               checks++; if (result_data_o !== exp_data || result_id_o !== id || result_rd_o !== rd || result_we_o !== 1'b1)
                  $display("FAIL rnd_result_%0d: got data=%h id=%0d rd=%0d we=%b want %h/%0d/%0d/1 (f3=%0d a=%h b=%h)",
                           it, result_data_o, result_id_o, result_rd_o, result_we_o, exp_data, id, rd, f3, a, b);
               else passes++;
               repeat ($urandom_range(0, 3)) @(negedge clk_i);
               take_result();
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_cadd();
      test_kill();
      test_same_cycle_bp();
      test_mul();
      test_reject();
      test_mismatch();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
